// File: rtl/lc3b_types.sv
// Shared L2 control types: FSM state enum and heap-indexed tree-PLRU helpers.
// Latency: pure combinational functions, no state.
// Backpressure: n/a.
package lc3b_types;

    // The helpers work on a tree sized for the largest legal way count.
    // Callers zero-extend their PLRU bits and pass the real way count.
    localparam int PLRU_MAX_WAYS = 32;
    localparam int PLRU_MAX_BITS = PLRU_MAX_WAYS - 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RESP      = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_FILL      = 2'd3
    } l2_state_t;

    // Walk from the root: bit 0 -> left child (2i+1), bit 1 -> right child (2i+2).
    // The walk stops at the first leaf node (index >= ways-1).
    function automatic logic [4:0] plru_victim(input logic [PLRU_MAX_BITS-1:0] plru,
                                               input int ways);
        logic [5:0] node;
        logic [5:0] leaf;
        node = '0;
        for (int lvl = 0; lvl < 5; lvl++) begin
            if (int'(node) < ways - 1) begin
                node = plru[node[4:0]] ? ({node[4:0], 1'b0} + 6'd2)
                                       : ({node[4:0], 1'b0} + 6'd1);
            end
        end
        leaf = node - 6'(ways - 1);
        return leaf[4:0];
    endfunction

    // Climb from the way's leaf to the root, pointing each parent away from
    // the child we came from: a left child (odd index) sets the parent to 1.
    function automatic logic [PLRU_MAX_BITS-1:0] plru_touch(input logic [PLRU_MAX_BITS-1:0] plru,
                                                            input logic [4:0] way,
                                                            input int ways);
        logic [PLRU_MAX_BITS-1:0] bits;
        logic [5:0] node;
        logic [5:0] parent;
        bits = plru;
        node = {1'b0, way} + 6'(ways - 1);
        for (int lvl = 0; lvl < 5; lvl++) begin
            if (node != 6'd0) begin
                parent = (node - 6'd1) >> 1;
                bits[parent[4:0]] = node[0];
                node = parent;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/l2_plru_tree.sv
// Victim selection (invalid way first, else tree-PLRU walk) and PLRU path update.
// Latency: combinational.
// Backpressure: n/a.
// Ports: i_plru/i_valid from the indexed set, i_touch_way is the accessed way;
//        o_victim is the replacement way, o_plru_touched the updated tree bits.
module l2_plru_tree
    import lc3b_types::*;
#(
    parameter  int WAYS     = 8,
    localparam int WAY_BITS = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]     i_plru,
    input  logic [WAYS-1:0]     i_valid,
    input  logic [WAY_BITS-1:0] i_touch_way,
    output logic [WAY_BITS-1:0] o_victim,
    output logic [WAYS-2:0]     o_plru_touched
);
    localparam int PB = WAYS - 1;

    logic [PLRU_MAX_BITS-1:0] w_plru_ext;
    logic [PLRU_MAX_BITS-1:0] w_touched_ext;
    logic [4:0]               w_tree_victim;

    always_comb begin
        w_plru_ext    = PLRU_MAX_BITS'(i_plru);
        w_tree_victim = plru_victim(w_plru_ext, WAYS);
        w_touched_ext = plru_touch(w_plru_ext, 5'(i_touch_way), WAYS);
        o_victim      = WAY_BITS'(w_tree_victim);
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!i_valid[w]) o_victim = WAY_BITS'(w);
        end
        o_plru_touched = PB'(w_touched_ext);
    end

endmodule

// File: rtl/l2_plru_cache_control.sv
// N-way write-back/write-allocate L2 control: hit service, victim writeback, line fill, perf counters.
// Latency: hit -> mem_resp next cycle; miss -> [WRITEBACK] + FILL, then the retried request hits.
// Backpressure: upstream holds mem_read/mem_write until mem_resp; pmem strobes held until pmem_resp.
// Ports: upstream (mem_*), physical memory (pmem_*), datapath set state in (hit, *_rd),
//        datapath array controls out (way_*, fill_sel, *_wr, plru_*, wb_addr_sel), saturating counters.
module l2_plru_cache_control
    import lc3b_types::*;
#(
    parameter  int WAYS      = 8,
    parameter  int CNT_WIDTH = 16,
    localparam int WAY_BITS  = $clog2(WAYS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 hit,
    input  logic [WAY_BITS-1:0]  hit_way,
    input  logic [WAYS-1:0]      valid_rd,
    input  logic [WAYS-1:0]      dirty_rd,
    input  logic [WAYS-2:0]      plru_rd,
    output logic [WAY_BITS-1:0]  way_sel,
    output logic                 way_write,
    output logic                 fill_sel,
    output logic                 valid_wr,
    output logic                 dirty_wr,
    output logic                 plru_write,
    output logic [WAYS-2:0]      plru_wr,
    output logic                 wb_addr_sel,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);
    l2_state_t            r_state;
    l2_state_t            w_next;
    logic [WAY_BITS-1:0]  r_victim;
    logic [CNT_WIDTH-1:0] r_hit_cnt;
    logic [CNT_WIDTH-1:0] r_miss_cnt;
    logic [CNT_WIDTH-1:0] r_wb_cnt;

    logic                 w_req;
    logic [WAY_BITS-1:0]  w_victim;
    logic [WAYS-2:0]      w_plru_touched;
    logic                 w_victim_ld;
    logic                 w_hit_inc;
    logic                 w_miss_inc;
    logic                 w_wb_inc;

    // A simultaneous read and write is a write; mem_write alone selects the write path.
    assign w_req = mem_read | mem_write;

    l2_plru_tree #(.WAYS(WAYS)) u_tree (
        .i_plru         (plru_rd),
        .i_valid        (valid_rd),
        .i_touch_way    (hit_way),
        .o_victim       (w_victim),
        .o_plru_touched (w_plru_touched)
    );

    always_comb begin
        w_next      = r_state;
        mem_resp    = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        way_sel     = '0;
        way_write   = 1'b0;
        fill_sel    = 1'b0;
        valid_wr    = 1'b0;
        dirty_wr    = 1'b0;
        plru_write  = 1'b0;
        plru_wr     = '0;
        wb_addr_sel = 1'b0;
        w_victim_ld = 1'b0;
        w_hit_inc   = 1'b0;
        w_miss_inc  = 1'b0;
        w_wb_inc    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req && hit) begin
                    plru_write = 1'b1;
                    plru_wr    = w_plru_touched;
                    way_sel    = hit_way;
                    if (mem_write) begin
                        way_write = 1'b1;
                        valid_wr  = 1'b1;
                        dirty_wr  = 1'b1;
                    end
                    w_hit_inc = 1'b1;
                    w_next    = ST_RESP;
                end else if (w_req) begin
                    w_victim_ld = 1'b1;
                    w_miss_inc  = 1'b1;
                    w_next      = (valid_rd[w_victim] && dirty_rd[w_victim]) ? ST_WRITEBACK : ST_FILL;
                end
            end
            ST_RESP: begin
                mem_resp = 1'b1;
                way_sel  = r_victim;
                w_next   = ST_IDLE;
            end
            ST_WRITEBACK: begin
                pmem_write  = 1'b1;
                wb_addr_sel = 1'b1;
                way_sel     = r_victim;
                if (pmem_resp) begin
                    w_wb_inc = 1'b1;
                    w_next   = ST_FILL;
                end
            end
            ST_FILL: begin
                pmem_read = 1'b1;
                way_sel   = r_victim;
                fill_sel  = 1'b1;
                if (pmem_resp) begin
                    way_write = 1'b1;
                    valid_wr  = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // A reset cycle must never commit anything into the arrays.
        if (!rst_n) begin
            way_write  = 1'b0;
            plru_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_victim   <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_victim_ld) r_victim <= w_victim;
            if (w_hit_inc && (r_hit_cnt != '1))   r_hit_cnt  <= r_hit_cnt + CNT_WIDTH'(1);
            if (w_miss_inc && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
            if (w_wb_inc && (r_wb_cnt != '1))     r_wb_cnt   <= r_wb_cnt + CNT_WIDTH'(1);
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
    assign wb_count   = r_wb_cnt;

endmodule
